// File: rtl/k_selftrigger_detector_if.sv
`default_nettype none
// ============================================================================
//  k_selftrigger_detector_if
//  Sample stream in / trigger and peak reports out for the self-trigger block.
//  Revision: 1.0
// ============================================================================
interface k_selftrigger_detector_if;
  logic               enable;
  logic signed [15:0] x;
  logic signed [15:0] baseline;
  logic        [14:0] threshold;
  logic               trigger;
  logic signed [15:0] peak;
  logic               peak_valid;
  logic               armed;

  modport master (
    output enable, x, baseline, threshold,
    input  trigger, peak, peak_valid, armed
  );

  modport slave (
    input  enable, x, baseline, threshold,
    output trigger, peak, peak_valid, armed
  );
endinterface
`default_nettype wire

// File: rtl/k_selftrigger_detector.sv
`default_nettype none
// ============================================================================
//  k_selftrigger_detector
//  Baseline-subtracted threshold trigger with run qualification, peak capture
//  and holdoff. Two pipeline stages feed a four-state detector.
//  Revision: 1.0
// ============================================================================
module k_selftrigger_detector #(
  parameter int CONSEC  = 4,
  parameter int HOLDOFF = 256
) (
  input  logic                      clk,
  input  logic                      reset_n,
  k_selftrigger_detector_if.slave   det
);

  localparam logic [1:0] S_ARMED    = 2'd0;
  localparam logic [1:0] S_COUNTING = 2'd1;
  localparam logic [1:0] S_FIRED    = 2'd2;
  localparam logic [1:0] S_HOLDOFF  = 2'd3;

  localparam logic [3:0]  c_consec  = 4'(CONSEC);
  localparam logic [15:0] c_holdoff = 16'(HOLDOFF);

  logic signed [15:0] r_x;
  logic signed [15:0] r_base;
  logic        [14:0] r_thr1;
  logic signed [15:0] r_amp;
  logic        [14:0] r_thr2;
  logic        [1:0]  r_state;
  logic        [3:0]  r_run;
  logic        [15:0] r_hcnt;
  logic signed [15:0] r_max;
  logic signed [15:0] r_peak;
  logic               r_trigger;
  logic               r_peak_valid;

  logic signed [16:0] w_diff;
  logic signed [15:0] w_amp_sat;
  logic               w_above;
  logic               w_below;
  logic        [3:0]  w_run_inc;
  logic        [15:0] w_hcnt_inc;
  logic signed [15:0] w_max_next;

  assign w_diff = {r_x[15], r_x} - {r_base[15], r_base};

  // Differing top two bits means the 17-bit difference left the 16-bit range
  always_comb begin
    w_amp_sat = w_diff[15:0];
    if (w_diff[16] != w_diff[15])
      w_amp_sat = w_diff[16] ? 16'sh8000 : 16'sh7FFF;
  end

  assign w_above    = $signed({r_amp[15], r_amp}) > $signed({2'b00, r_thr2});
  assign w_below    = $signed({r_amp[15], r_amp}) < $signed({3'b000, r_thr2[14:1]});
  assign w_run_inc  = r_run + 4'd1;
  assign w_hcnt_inc = (r_hcnt == 16'hFFFF) ? r_hcnt : r_hcnt + 16'd1;
  assign w_max_next = (r_amp > r_max) ? r_amp : r_max;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x          <= '0;
      r_base       <= '0;
      r_thr1       <= '0;
      r_amp        <= '0;
      r_thr2       <= '0;
      r_state      <= S_ARMED;
      r_run        <= '0;
      r_hcnt       <= '0;
      r_max        <= '0;
      r_peak       <= '0;
      r_trigger    <= 1'b0;
      r_peak_valid <= 1'b0;
    end else if (!det.enable) begin
      r_trigger    <= 1'b0;
      r_peak_valid <= 1'b0;
    end else begin
      r_x          <= det.x;
      r_base       <= det.baseline;
      r_thr1       <= det.threshold;
      r_amp        <= w_amp_sat;
      r_thr2       <= r_thr1;
      r_trigger    <= 1'b0;
      r_peak_valid <= 1'b0;

      case (r_state)
        S_ARMED: begin
          if (w_above) begin
            r_max <= r_amp;
            r_run <= 4'd1;
            if (c_consec == 4'd1) begin
              r_state   <= S_FIRED;
              r_hcnt    <= 16'd1;
              r_trigger <= 1'b1;
            end else begin
              r_state <= S_COUNTING;
            end
          end
        end

        S_COUNTING: begin
          if (w_above) begin
            r_run <= w_run_inc;
            r_max <= w_max_next;
            if (w_run_inc == c_consec) begin
              r_state   <= S_FIRED;
              r_hcnt    <= 16'd1;
              r_trigger <= 1'b1;
            end
          end else begin
            r_state <= S_ARMED;
            r_run   <= '0;
          end
        end

        S_FIRED: begin
          r_max  <= w_max_next;
          r_hcnt <= w_hcnt_inc;
          if (w_below) begin
            r_peak       <= w_max_next;
            r_peak_valid <= 1'b1;
            r_state      <= S_HOLDOFF;
          end
        end

        default: begin
          // Re-arm needs both the elapsed time and a quiet sample
          if (w_below && (r_hcnt >= c_holdoff)) begin
            r_state <= S_ARMED;
            r_run   <= '0;
          end else begin
            r_hcnt <= w_hcnt_inc;
          end
        end
      endcase
    end
  end

  assign det.trigger    = r_trigger;
  assign det.peak_valid = r_peak_valid;
  assign det.peak       = r_peak;
  assign det.armed      = (r_state == S_ARMED);

endmodule
`default_nettype wire

// File: doc/k_selftrigger_detector.md
K_SELFTRIGGER_DETECTOR -- requirements
Module: k_selftrigger_detector

Interface
REQ-001 SHALL have parameter CONSEC, default 4, meaning consecutive above-threshold samples required to fire (1..15).
REQ-002 SHALL have parameter HOLDOFF, default 256, meaning minimum cycles from trigger to re-arm (1..65535).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port enable  input  1  sample-valid qualifier; when low the entire block holds state.
REQ-006 SHALL have port x  input  16 signed  filtered sample stream.
REQ-007 SHALL have port baseline  input  16 signed  low-pass baseline estimate from the k-filter output.
REQ-008 SHALL have port threshold  input  15 unsigned  trigger level, sampled with x.
REQ-009 SHALL have port trigger  output  1  one-cycle pulse when a trigger fires.
REQ-010 SHALL have port peak  output  16 signed  maximum amplitude of the last completed pulse.
REQ-011 SHALL have port peak_valid  output  1  one-cycle pulse when peak updates.
REQ-012 SHALL have port armed  output  1  high in ARMED state only.

Function
REQ-013 SHALL register x, baseline and threshold on enabled edges (stage 1).
REQ-014 SHALL compute amplitude = x_reg - baseline_reg at 17 bits signed, saturate to [-32768, 32767], and register it (stage 2).
REQ-015 SHALL define "above" as amplitude > threshold and "below" as amplitude < threshold/2 (threshold >> 1); equality is not above.
REQ-016 SHALL implement states ARMED, COUNTING, FIRED, HOLDOFF, with reset state ARMED.
REQ-017 SHALL transition from ARMED to COUNTING on an above sample, loading the run counter with 1.
REQ-018 SHALL increment the run counter in COUNTING on each above sample, and return to ARMED with the counter cleared on any non-above sample.
REQ-019 SHALL enter FIRED when the run counter reaches CONSEC, including directly from ARMED when CONSEC=1.
REQ-020 SHALL assert trigger for exactly one cycle on entry to FIRED, registered, so that trigger is high in the cycle after the third enabled edge following presentation of the qualifying sample.
REQ-021 SHALL, from COUNTING onward, track the running maximum amplitude, initialised to the first above sample.
REQ-022 SHALL, in FIRED, keep tracking the maximum and start the holdoff counter at 1 on entry.
REQ-023 SHALL leave FIRED for HOLDOFF on the first below sample, and on that edge load peak with the tracked maximum and pulse peak_valid for one cycle.
REQ-024 SHALL have the holdoff counter keep counting through FIRED and HOLDOFF on enabled edges, saturating at 65535.
REQ-025 SHALL return from HOLDOFF to ARMED only when the holdoff count >= HOLDOFF and the current sample is below; otherwise it SHALL stay in HOLDOFF.
REQ-026 SHALL NOT emit a second trigger between entry to FIRED and return to ARMED, regardless of amplitude.
REQ-027 SHALL, when enable is low, advance no pipeline stage, counter or state; trigger and peak_valid SHALL be low and peak SHALL hold.
REQ-028 SHALL emit trigger and peak_valid only on enabled edges; trigger and peak_valid SHALL never be high in the same cycle.
REQ-029 SHALL fire normally when threshold = 0, with release requiring amplitude < 0.

Reset
REQ-030 SHALL, on reset_n low, asynchronously clear all pipeline registers, counters and the maximum to 0, set state to ARMED, and drive trigger=0, peak_valid=0, peak=0, armed=1.
REQ-031 SHALL, on reset asserted mid-pulse (COUNTING, FIRED or HOLDOFF), discard the pulse with no peak_valid, and resume from ARMED on the first edge after release.
REQ-032 SHALL deassert reset_n synchronously to clk, with no edge-dependent glitch on outputs.

Verification
REQ-033 SHALL cover basic fire: CONSEC=4, threshold=100, baseline=0, x=200 held for 4 enabled samples -> one trigger pulse 3 edges after the 4th sample, armed low.
REQ-034 SHALL cover broken run: x=200,200,200,50,200,200,200,200 -> no trigger until the 4th 200 after the 50.
REQ-035 SHALL cover peak: pulse 0,150,300,450,300,150,40,0 with threshold=100 and CONSEC=2 -> peak_valid on the 40 sample with peak=450.
REQ-036 SHALL cover holdoff: HOLDOFF=16 and a second qualifying pulse 10 cycles after trigger -> no trigger; the same pulse at cycle 30 -> trigger.
REQ-037 SHALL cover saturation: x=32767, baseline=-32768 -> amplitude 32767, and a later peak of 32767 with no wrap.
REQ-038 SHALL cover enable and reset: enable low for 5 cycles mid-run -> trigger delayed exactly 5 cycles; reset_n low during FIRED -> outputs cleared immediately, no peak_valid.
